peak_result_packer: RTL and testbench

- Sits downstream of the per-range-bin peak detection stage in the user-logic signal-processing chain.
- Captures one peak result (value, FFT bin address) per range bin during a group.
- On group end, serialises a framed result record onto the 32-bit output lane pair (y0z_o:y0_o) with a valid strobe, honouring a downstream ready.

---
 rtl/peak_result_packer_pkg.sv | 68 ++++++
 rtl/peak_result_packer_next_valid.sv | 23 ++
 rtl/peak_result_packer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_peak_result_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/peak_result_packer_pkg.sv
// Shared definitions for the peak result packer: state encoding, beat tags,
// beat field offsets and small packing / checksum helpers.
package peak_result_packer_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_HDR     = 3'd1,
    ST_BIN_A   = 3'd2,
    ST_BIN_B   = 3'd3,
    ST_TRAIL   = 3'd4
  } state_e;

  localparam logic [15:0] HEADER_TAG  = 16'hC0DE;
  localparam logic [15:0] TRAILER_TAG = 16'hE0F0;

  // Index width used for bin indices on the scan and in the beats
  localparam int IDX_W = 5;

  // Header lower lane: {group_seq[10:0], count[4:0]}
  localparam int HDR_COUNT_LSB = 0;
  localparam int HDR_COUNT_W   = 5;
  localparam int HDR_SEQ_LSB   = 5;
  localparam int HDR_SEQ_W     = 11;

  // BIN_A upper lane: {1'b1, idx[4:0], addr[9:0]}
  localparam int BIN_A_ADDR_LSB = 0;
  localparam int BIN_A_ADDR_W   = 10;
  localparam int BIN_A_IDX_LSB  = 10;
  localparam int BIN_A_IDX_W    = 5;
  localparam int BIN_A_FLAG_BIT = 15;

  function automatic logic [15:0] pack_hdr(input logic [HDR_SEQ_W-1:0] seq,
                                           input logic [HDR_COUNT_W-1:0] count);
    logic [15:0] b;
    b = 16'd0;
    b[HDR_SEQ_LSB +: HDR_SEQ_W]     = seq;
    b[HDR_COUNT_LSB +: HDR_COUNT_W] = count;
    return b;
  endfunction

  function automatic logic [15:0] pack_bin_a(input logic [BIN_A_IDX_W-1:0] idx,
                                             input logic [BIN_A_ADDR_W-1:0] addr);
    logic [15:0] b;
    b = 16'd0;
    b[BIN_A_FLAG_BIT]                 = 1'b1;
    b[BIN_A_IDX_LSB +: BIN_A_IDX_W]   = idx;
    b[BIN_A_ADDR_LSB +: BIN_A_ADDR_W] = addr;
    return b;
  endfunction

  // Number of set bits, saturated to what the 5-bit header field can carry
  function automatic logic [HDR_COUNT_W-1:0] count_sat(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return (n > 6'd31) ? 5'd31 : n[4:0];
  endfunction

  // Running record checksum: fold both lanes of one beat into the accumulator
  function automatic logic [15:0] chk_fold(input logic [15:0] acc,
                                           input logic [15:0] hi,
                                           input logic [15:0] lo);
    return acc ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/peak_result_packer_next_valid.sv
// Priority encoder: lowest valid index that is >= start, plus a found flag.
module peak_result_next_valid
  import peak_result_packer_pkg::*;
#(
  parameter int NofRangeBins = 16
) (
  input  logic [NofRangeBins-1:0] valid,
  input  logic [5:0]              start,
  output logic [IDX_W-1:0]        idx,
  output logic                    found
);

  // Scan downward so the lowest qualifying index is the last one taken
  always_comb begin
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
    for (int i = NofRangeBins - 1; i >= 0; i--) begin
      idx   = (valid[i] && (6'(i) >= start)) ? IDX_W'(i) : idx;
      found = found | (valid[i] && (6'(i) >= start));
    end
  end

endmodule

// File: rtl/peak_result_packer.sv
// Peak result packer: collects one peak per range bin during a group and, on
// flush, streams a framed record (header, then two beats per valid bin) over
// the y0z_o:y0_o lane pair with a valid/ready handshake.
// Optional build macro PEAK_RESULT_PACKER_CHECKSUM_EN appends a trailer beat
// carrying the XOR of all preceding lane halves of the record.
module peak_result_packer
  import peak_result_packer_pkg::*;
#(
  parameter int          NofBits      = 16,
  parameter int          NofRangeBins = 16,
  parameter int          PeakAddrBits = 10,
  parameter logic [15:0] HeaderTag    = HEADER_TAG
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    peak_valid_i,
  input  logic [31:0]             peak_value_i,
  input  logic [PeakAddrBits-1:0] peak_addr_i,
  input  logic [4:0]              range_bin_i,
  input  logic                    flush_i,
  input  logic                    out_ready_i,
  output logic [NofBits-1:0]      y0z_o,
  output logic [NofBits-1:0]      y0_o,
  output logic                    data_valid_o,
  output logic                    frame_start_o,
  output logic                    busy_o,
  output logic                    overflow_o
);

  localparam int SLOT_W = (NofRangeBins > 1) ? $clog2(NofRangeBins) : 1;

  // Result storage
  logic [NofRangeBins-1:0] valid_r;
  logic [31:0]             value_r [0:NofRangeBins-1];
  logic [PeakAddrBits-1:0] addr_r  [0:NofRangeBins-1];

  // Control and presented beat
  state_e           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [15:0]      y0z_r, y0z_s, y0_r, y0_s;
  logic             dv_r, dv_s, fs_r, fs_s;
  logic             busy_r, ovf_r;
  logic [15:0]      seq_r;
  logic             done_s;

`ifdef PEAK_RESULT_PACKER_CHECKSUM_EN
  logic [15:0]      chk_r, chk_s;
`endif

  // Datapath helpers
  logic                    in_range_s, collect_s, wr_en_s, drop_s, accept_s;
  logic [SLOT_W-1:0]       wr_slot_s, cur_slot_s, nv_slot_s;
  logic [HDR_COUNT_W-1:0]  count_s;
  logic [5:0]              start_s;
  logic [IDX_W-1:0]        nv_idx_s;
  logic                    nv_found_s;
  logic [BIN_A_ADDR_W-1:0] nv_addr_s;

  // Beat that follows HDR or a BIN_B
  state_e      bnd_state_s;
  logic [15:0] bnd_y0z_s, bnd_y0_s;
  logic        bnd_dv_s, bnd_done_s;

  assign collect_s  = (state_r == ST_COLLECT);
  assign in_range_s = ({1'b0, range_bin_i} < 6'(NofRangeBins));
  assign wr_en_s    = peak_valid_i && collect_s && in_range_s;
  assign drop_s     = peak_valid_i && !(collect_s && in_range_s);
  assign accept_s   = dv_r && out_ready_i;
  assign wr_slot_s  = range_bin_i[SLOT_W-1:0];
  assign cur_slot_s = idx_r[SLOT_W-1:0];
  assign nv_slot_s  = nv_idx_s[SLOT_W-1:0];
  assign nv_addr_s  = BIN_A_ADDR_W'(addr_r[nv_slot_s]);
  assign count_s    = count_sat(32'(valid_r));
  // Header scans from bin 0; after a BIN_B the scan resumes just past the current bin
  assign start_s    = (state_r == ST_HDR) ? 6'd0 : ({1'b0, idx_r} + 6'd1);

  peak_result_next_valid #(
    .NofRangeBins (NofRangeBins)
  ) u_next_valid (
    .valid (valid_r),
    .start (start_s),
    .idx   (nv_idx_s),
    .found (nv_found_s)
  );

  // Result register file: written only while collecting, cleared when a record closes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_r <= {NofRangeBins{1'b0}};
      for (int i = 0; i < NofRangeBins; i++) begin
        value_r[i] <= 32'd0;
        addr_r[i]  <= {PeakAddrBits{1'b0}};
      end
    end else if (done_s) begin
      valid_r <= {NofRangeBins{1'b0}};
    end else if (wr_en_s) begin
      valid_r[wr_slot_s] <= 1'b1;
      value_r[wr_slot_s] <= peak_value_i;
      addr_r[wr_slot_s]  <= peak_addr_i;
    end
  end

`ifdef PEAK_RESULT_PACKER_CHECKSUM_EN
  // Running XOR of every accepted beat; zero whenever no record is in flight
  always_comb begin
    if (state_r == ST_COLLECT) begin
      chk_s = 16'd0;
    end else if (accept_s) begin
      chk_s = chk_fold(chk_r, y0z_r, y0_r);
    end else begin
      chk_s = chk_r;
    end
  end

  // Checksum accumulator register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      chk_r <= 16'd0;
    end else begin
      chk_r <= chk_s;
    end
  end
`endif

  // Pick the beat after a bin boundary: next valid bin, else trailer or record end
  always_comb begin
    bnd_state_s = ST_COLLECT;
    bnd_y0z_s   = 16'd0;
    bnd_y0_s    = 16'd0;
    bnd_dv_s    = 1'b0;
    bnd_done_s  = 1'b0;
    if (nv_found_s) begin
      bnd_state_s = ST_BIN_A;
      bnd_y0z_s   = pack_bin_a(nv_idx_s, nv_addr_s);
      bnd_y0_s    = seq_r;
      bnd_dv_s    = 1'b1;
    end else begin
`ifdef PEAK_RESULT_PACKER_CHECKSUM_EN
      bnd_state_s = ST_TRAIL;
      bnd_y0z_s   = TRAILER_TAG;
      bnd_y0_s    = chk_fold(chk_r, y0z_r, y0_r);
      bnd_dv_s    = 1'b1;
`else
      bnd_done_s  = 1'b1;
`endif
    end
  end

  // Next state and next presented beat; a beat only changes when it is accepted
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    y0z_s   = y0z_r;
    y0_s    = y0_r;
    dv_s    = dv_r;
    fs_s    = fs_r;
    done_s  = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        if (flush_i) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_HDR: begin
        if (!dv_r) begin
          y0z_s = HeaderTag;
          y0_s  = pack_hdr(seq_r[HDR_SEQ_W-1:0], count_s);
          dv_s  = 1'b1;
          fs_s  = 1'b1;
        end else if (accept_s) begin
          state_s = bnd_state_s;
          idx_s   = nv_idx_s;
          y0z_s   = bnd_y0z_s;
          y0_s    = bnd_y0_s;
          dv_s    = bnd_dv_s;
          fs_s    = 1'b0;
          done_s  = bnd_done_s;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_BIN_A: begin
        if (accept_s) begin
          state_s = ST_BIN_B;
          y0z_s   = value_r[cur_slot_s][31:16];
          y0_s    = value_r[cur_slot_s][15:0];
        end else begin
          state_s = ST_BIN_A;
        end
      end
      ST_BIN_B: begin
        if (accept_s) begin
          state_s = bnd_state_s;
          idx_s   = nv_idx_s;
          y0z_s   = bnd_y0z_s;
          y0_s    = bnd_y0_s;
          dv_s    = bnd_dv_s;
          fs_s    = 1'b0;
          done_s  = bnd_done_s;
        end else begin
          state_s = ST_BIN_B;
        end
      end
      ST_TRAIL: begin
        if (accept_s) begin
          state_s = ST_COLLECT;
          y0z_s   = 16'd0;
          y0_s    = 16'd0;
          dv_s    = 1'b0;
          fs_s    = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = ST_TRAIL;
        end
      end
      default: begin
        state_s = ST_COLLECT;
        y0z_s   = 16'd0;
        y0_s    = 16'd0;
        dv_s    = 1'b0;
        fs_s    = 1'b0;
      end
    endcase
  end

  // State, presented beat, group sequence and status flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_COLLECT;
      idx_r   <= {IDX_W{1'b0}};
      y0z_r   <= 16'd0;
      y0_r    <= 16'd0;
      dv_r    <= 1'b0;
      fs_r    <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
      seq_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      y0z_r   <= y0z_s;
      y0_r    <= y0_s;
      dv_r    <= dv_s;
      fs_r    <= fs_s;
      busy_r  <= (state_s != ST_COLLECT);
      ovf_r   <= ovf_r | drop_s;
      if (done_s) begin
        seq_r <= seq_r + 16'd1;
      end
    end
  end

  assign y0z_o         = NofBits'(y0z_r);
  assign y0_o          = NofBits'(y0_r);
  assign data_valid_o  = dv_r;
  assign frame_start_o = fs_r;
  assign busy_o        = busy_r;
  assign overflow_o    = ovf_r;

endmodule

// File: tb/tb_peak_result_packer.sv
// Directed, cycle-exact bench for peak_result_packer. Each record is described
// as a table of per-cycle entries (ready to drive, expected outputs) that is
// applied and compared in a loop; reset and overflow corners are hand-written.
// Follows PEAK_RESULT_PACKER_CHECKSUM_EN to expect the trailer beat.
module tb_peak_result_packer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        peak_valid_i;
  logic [31:0] peak_value_i;
  logic [9:0]  peak_addr_i;
  logic [4:0]  range_bin_i;
  logic        flush_i;
  logic        out_ready_i;
  logic [15:0] y0z_o;
  logic [15:0] y0_o;
  logic        data_valid_o;
  logic        frame_start_o;
  logic        busy_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  peak_result_packer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .peak_valid_i  (peak_valid_i),
    .peak_value_i  (peak_value_i),
    .peak_addr_i   (peak_addr_i),
    .range_bin_i   (range_bin_i),
    .flush_i       (flush_i),
    .out_ready_i   (out_ready_i),
    .y0z_o         (y0z_o),
    .y0_o          (y0_o),
    .data_valid_o  (data_valid_o),
    .frame_start_o (frame_start_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o)
  );

  typedef struct {
    logic        rdy;   // out_ready_i driven after this sample
    logic        inj;   // drive a stray peak (bin 5) after this sample
    logic        dv;
    logic        fs;
    logic        busy;
    logic [15:0] y0z;
    logic [15:0] y0;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] chk_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rdy, input logic inj, input logic dv,
                              input logic fs, input logic busy, input logic [15:0] y0z,
                              input logic [15:0] y0, input logic acc);
    vec_t v;
    v.rdy = rdy; v.inj = inj; v.dv = dv; v.fs = fs; v.busy = busy; v.y0z = y0z; v.y0 = y0;
    vq.push_back(v);
    if (acc) chk_m = chk_m ^ y0z ^ y0;
  endfunction

  // First cycle after flush: busy, no beat yet
  function automatic void begin_rec(input logic inj);
    chk_m = 16'd0;
    add(1'b1, inj, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
  endfunction

  function automatic void beat(input logic rdy, input logic fs, input logic [15:0] y0z, input logic [15:0] y0);
    add(rdy, 1'b0, 1'b1, fs, 1'b1, y0z, y0, 1'b1);
  endfunction

  function automatic void hold(input logic rdy, input logic [15:0] y0z, input logic [15:0] y0);
    add(rdy, 1'b0, 1'b1, 1'b0, 1'b1, y0z, y0, 1'b0);
  endfunction

  function automatic void end_rec();
`ifdef PEAK_RESULT_PACKER_CHECKSUM_EN
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hE0F0, chk_m, 1'b0);
`endif
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endfunction

  task automatic run_table(input string name);
    for (int k = 0; k < vq.size(); k++) begin
      check($sformatf("%s[%0d]", name, k),
            {29'd0, data_valid_o, frame_start_o, busy_o, y0z_o, y0_o},
            {29'd0, vq[k].dv, vq[k].fs, vq[k].busy, vq[k].y0z, vq[k].y0});
      out_ready_i  = vq[k].rdy;
      peak_valid_i = vq[k].inj;
      if (vq[k].inj) begin
        range_bin_i  = 5'd5;
        peak_value_i = 32'h0000DEAD;
        peak_addr_i  = 10'd9;
      end
      @(negedge clk);
    end
    peak_valid_i = 1'b0;
    out_ready_i  = 1'b1;
    vq.delete();
  endtask

  task automatic write_peak(input logic [4:0] bin, input logic [31:0] val, input logic [9:0] addr);
    @(negedge clk);
    peak_valid_i = 1'b1;
    range_bin_i  = bin;
    peak_value_i = val;
    peak_addr_i  = addr;
    @(negedge clk);
    peak_valid_i = 1'b0;
  endtask

  task automatic do_flush(input logic with_pk, input logic [4:0] bin,
                          input logic [31:0] val, input logic [9:0] addr);
    @(negedge clk);
    flush_i      = 1'b1;
    peak_valid_i = with_pk;
    range_bin_i  = bin;
    peak_value_i = val;
    peak_addr_i  = addr;
    @(negedge clk);
    flush_i      = 1'b0;
    peak_valid_i = 1'b0;
  endtask

  initial begin
    int seen;
    rst_i = 1'b0; peak_valid_i = 1'b0; peak_value_i = 32'd0; peak_addr_i = 10'd0;
    range_bin_i = 5'd0; flush_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {28'd0, data_valid_o, frame_start_o, busy_o, overflow_o, y0z_o, y0_o}, 64'd0);
    rst_i = 1'b1;

    // Scenario 1: bins 0, 3, 7
    write_peak(5'd0, 32'h00012345, 10'd5);
    write_peak(5'd3, 32'h00000007, 10'd512);
    write_peak(5'd7, 32'hFFFFFFFF, 10'd1023);
    do_flush(1'b0, 5'd0, 32'd0, 10'd0);
    begin_rec(1'b0);
    beat(1'b1, 1'b1, 16'hC0DE, 16'h0003);
    beat(1'b1, 1'b0, 16'h8005, 16'h0000);
    beat(1'b1, 1'b0, 16'h0001, 16'h2345);
    beat(1'b1, 1'b0, 16'h8E00, 16'h0000);
    beat(1'b1, 1'b0, 16'h0000, 16'h0007);
    beat(1'b1, 1'b0, 16'h9FFF, 16'h0000);
    beat(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    end_rec();
    run_table("s1_three_bins");

    // Scenario 2: empty group, group_seq now 1
    do_flush(1'b0, 5'd0, 32'd0, 10'd0);
    begin_rec(1'b0);
    beat(1'b1, 1'b1, 16'hC0DE, 16'h0020);
    end_rec();
    run_table("s2_empty");

    // Scenario 3: BIN_A held by ready 0,0 then accepted
    write_peak(5'd1, 32'hABCD1234, 10'd3);
    do_flush(1'b0, 5'd0, 32'd0, 10'd0);
    begin_rec(1'b0);
    beat(1'b1, 1'b1, 16'hC0DE, 16'h0041);
    beat(1'b0, 1'b0, 16'h8403, 16'h0002);
    hold(1'b0, 16'h8403, 16'h0002);
    hold(1'b1, 16'h8403, 16'h0002);
    beat(1'b1, 1'b0, 16'hABCD, 16'h1234);
    end_rec();
    run_table("s3_backpressure");
    check("ovf_clear_before_s4", {63'd0, overflow_o}, 64'd0);

    // Scenario 4: peak with flush is kept; stray peak during emission dropped
    do_flush(1'b1, 5'd2, 32'h000055AA, 10'h155);
    begin_rec(1'b1);
    beat(1'b1, 1'b1, 16'hC0DE, 16'h0061);
    beat(1'b1, 1'b0, 16'h8955, 16'h0003);
    beat(1'b1, 1'b0, 16'h0000, 16'h55AA);
    end_rec();
    run_table("s4_flush_same_cycle");
    check("ovf_after_busy_drop", {63'd0, overflow_o}, 64'd1);

    // Scenario 6: reset in the middle of a record
    write_peak(5'd6, 32'h00000001, 10'd1);
    do_flush(1'b0, 5'd0, 32'd0, 10'd0);
    out_ready_i = 1'b1;
    @(negedge clk);
    check("s6_hdr", {31'd0, data_valid_o, frame_start_o, y0z_o, y0_o},
          {31'd0, 1'b1, 1'b1, 16'hC0DE, 16'h0081});
    @(negedge clk);
    check("s6_bin_a", {31'd0, data_valid_o, frame_start_o, y0z_o, y0_o},
          {31'd0, 1'b1, 1'b0, 16'h9801, 16'h0004});
    #2 rst_i = 1'b0;
    #1;
    check("s6_reset_outputs",
          {28'd0, data_valid_o, frame_start_o, busy_o, overflow_o, y0z_o, y0_o}, 64'd0);
    @(negedge clk);
    rst_i = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_valid_o || busy_o) seen++;
    end
    check("s6_no_beats_after_reset", 64'(seen), 64'd0);

    // Scenario 5: last write wins; out-of-range bin sets overflow (group_seq back to 0)
    write_peak(5'd4, 32'd10, 10'd7);
    write_peak(5'd4, 32'd20, 10'd8);
    check("s5_ovf_before", {63'd0, overflow_o}, 64'd0);
    write_peak(5'd20, 32'd99, 10'd1);
    check("s5_ovf_out_of_range", {63'd0, overflow_o}, 64'd1);
    do_flush(1'b0, 5'd0, 32'd0, 10'd0);
    begin_rec(1'b0);
    beat(1'b1, 1'b1, 16'hC0DE, 16'h0001);
    beat(1'b1, 1'b0, 16'h9008, 16'h0000);
    beat(1'b1, 1'b0, 16'h0000, 16'h0014);
    end_rec();
    run_table("s5_overwrite");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
